lbus2axis_pkt_fifo: RTL and testbench

Parametrised LBUS-to-AXI4-Stream receive converter for 2- or 4-segment LBUS MACs. It packs segments into dense AXIS beats and buffers them in a store-and-forward packet FIFO. The FIFO gives the downstream AXIS consumer full tready backpressure, which LBUS RX cannot provide. Overflowing, errored and malformed packets are dropped whole and counted. It sits between the MAC RX LBUS and the stack RX AXIS path.

---
 rtl/lbus2axis_pkt_fifo.sv | 246 ++++++++++++++++++++++++
 tb/tb_lbus2axis_pkt_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbus2axis_pkt_fifo.sv
// LBUS (2/4 segment) receive to AXI4-Stream converter.
// Stage 1 registers the LBUS inputs, stage 2 packs segments into dense beats
// and writes them into a store-and-forward packet FIFO. The read side only
// sees committed packets and drives a registered AXIS output stage.
module lbus2axis_pkt_fifo #(
  parameter int NUM_SEG  = 4,
  parameter int DEPTH    = 64,
  parameter int DROP_ERR = 1,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [128*NUM_SEG-1:0] rx_lbus_data,
  input  logic [NUM_SEG-1:0]     rx_lbus_ena,
  input  logic [NUM_SEG-1:0]     rx_lbus_sop,
  input  logic [NUM_SEG-1:0]     rx_lbus_eop,
  input  logic [4*NUM_SEG-1:0]   rx_lbus_mty,
  input  logic [NUM_SEG-1:0]     rx_lbus_err,
  output logic [128*NUM_SEG-1:0] m_axis_tdata,
  output logic [16*NUM_SEG-1:0]  m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [CNT_W-1:0]       pkt_cnt,
  output logic [CNT_W-1:0]       drop_ovf_cnt,
  output logic [CNT_W-1:0]       drop_err_cnt
);
  localparam int DW = 128*NUM_SEG;
  localparam int KW = 16*NUM_SEG;
  localparam int EW = DW + KW + 2;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(NUM_SEG);
  localparam int FW = $clog2(NUM_SEG + 1);

  typedef enum logic [1:0] {S_IDLE, S_PKT, S_DROP} state_t;

  // ---- stage 1: registered LBUS inputs ----
  logic [DW-1:0]        r_data_p1;
  logic [4*NUM_SEG-1:0] r_mty_p1;
  logic [NUM_SEG-1:0]   r_err_p1, r_ena_p1, r_sop_p1, r_eop_p1;

  // Control qualifiers are reset so no phantom segment follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ena_p1 <= '0;
      r_sop_p1 <= '0;
      r_eop_p1 <= '0;
    end else begin
      r_ena_p1 <= rx_lbus_ena;
      r_sop_p1 <= rx_lbus_sop;
      r_eop_p1 <= rx_lbus_eop;
    end
  end

  // Payload side of the input register, qualified by r_ena_p1.
  always_ff @(posedge clk) begin
    r_data_p1 <= rx_lbus_data;
    r_mty_p1  <= rx_lbus_mty;
    r_err_p1  <= rx_lbus_err;
  end

  // ---- stage 2: packer / FSM / FIFO write ----
  state_t           r_state, w_state;
  logic [FW-1:0]    r_fill, w_fill;
  logic [127:0]     r_slot_data [NUM_SEG];
  logic [127:0]     w_slot_data [NUM_SEG];
  logic [15:0]      r_slot_keep [NUM_SEG];
  logic [15:0]      w_slot_keep [NUM_SEG];
  logic             r_err_acc, w_err_acc;
  logic [PW-1:0]    r_wr_ptr, w_wr_ptr, r_pkt_start, w_pkt_start;
  logic [PW-1:0]    r_commit_ptr, w_commit, r_rd_ptr, r_rel_ptr, w_occ;
  logic [CNT_W-1:0] r_pkt_cnt, r_ovf_cnt, r_err_cnt, w_n_pkt, w_n_ovf, w_n_err;
  logic [SW-1:0]    w_nw;
  logic             w_we    [NUM_SEG];
  logic [AW-1:0]    w_waddr [NUM_SEG];
  logic [EW-1:0]    w_wentry[NUM_SEG];
  logic [127:0]     w_seg_d;
  logic             w_seg_eop;
  logic [DW-1:0]    w_beat_d;
  logic [KW-1:0]    w_beat_k;
  logic [EW-1:0]    r_mem [DEPTH];

  // Walk the segments in order; each completed beat is overflow-checked on its
  // own, so an ending packet is judged before one starting later in the cycle.
  // Free space is measured against r_rel_ptr so the beat held in the output
  // register still occupies its FIFO entry until handshaken.
  always_comb begin
    w_state     = r_state;
    w_fill      = r_fill;
    w_slot_data = r_slot_data;
    w_slot_keep = r_slot_keep;
    w_err_acc   = r_err_acc;
    w_wr_ptr    = r_wr_ptr;
    w_pkt_start = r_pkt_start;
    w_commit    = r_commit_ptr;
    w_n_pkt     = '0;
    w_n_ovf     = '0;
    w_n_err     = '0;
    w_nw        = '0;
    w_seg_d     = '0;
    w_seg_eop   = 1'b0;
    w_beat_d    = '0;
    w_beat_k    = '0;
    w_occ       = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      w_we[i]     = 1'b0;
      w_waddr[i]  = '0;
      w_wentry[i] = '0;
    end
    for (int s = 0; s < NUM_SEG; s++) begin
      if (r_ena_p1[s]) begin
        w_seg_d   = r_data_p1[128*(NUM_SEG-s)-1 -: 128];
        w_seg_eop = r_eop_p1[s];
        if (r_sop_p1[s]) begin
          if (w_state == S_PKT) begin
            // sop inside a packet: the unfinished packet is malformed
            w_wr_ptr = w_pkt_start;
            w_n_err  = w_n_err + CNT_W'(1);
          end
          w_state     = S_PKT;
          w_pkt_start = w_wr_ptr;
          w_err_acc   = 1'b0;
          w_fill      = '0;
        end
        if (w_state == S_PKT) begin
          w_err_acc = w_err_acc | r_err_p1[s];
          w_slot_data[w_fill[SW-1:0]] = w_seg_d;
          w_slot_keep[w_fill[SW-1:0]] = w_seg_eop ? (16'hFFFF << r_mty_p1[4*s +: 4]) : 16'hFFFF;
          w_fill = w_fill + FW'(1);
          if (w_fill == FW'(NUM_SEG) || w_seg_eop) begin
            w_occ = w_wr_ptr - r_rel_ptr;
            if (w_occ >= PW'(DEPTH)) begin
              w_wr_ptr = w_pkt_start;
              w_n_ovf  = w_n_ovf + CNT_W'(1);
              w_fill   = '0;
              w_state  = w_seg_eop ? S_IDLE : S_DROP;
            end else begin
              for (int k = 0; k < NUM_SEG; k++) begin
                w_beat_d[128*(NUM_SEG-k)-1 -: 128] = (FW'(k) < w_fill) ? w_slot_data[k] : '0;
                w_beat_k[16*(NUM_SEG-k)-1 -: 16]   = (FW'(k) < w_fill) ? w_slot_keep[k] : '0;
              end
              w_we[w_nw]     = 1'b1;
              w_waddr[w_nw]  = w_wr_ptr[AW-1:0];
              w_wentry[w_nw] = {w_beat_d, w_beat_k, w_seg_eop, w_seg_eop & w_err_acc};
              w_nw           = w_nw + SW'(1);
              w_wr_ptr       = w_wr_ptr + PW'(1);
              w_fill         = '0;
              if (w_seg_eop) begin
                if (DROP_ERR != 0 && w_err_acc) begin
                  w_wr_ptr = w_pkt_start;
                  w_n_err  = w_n_err + CNT_W'(1);
                end else begin
                  w_commit = w_wr_ptr;
                  w_n_pkt  = w_n_pkt + CNT_W'(1);
                end
                w_state = S_IDLE;
              end
            end
          end
        end else if (w_state == S_DROP && w_seg_eop) begin
          w_state = S_IDLE;
        end
      end
    end
  end

  // Packer state, write pointers and drop/commit counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_fill       <= '0;
      r_err_acc    <= 1'b0;
      r_wr_ptr     <= '0;
      r_pkt_start  <= '0;
      r_commit_ptr <= '0;
      r_pkt_cnt    <= '0;
      r_ovf_cnt    <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state;
      r_fill       <= w_fill;
      r_err_acc    <= w_err_acc;
      r_wr_ptr     <= w_wr_ptr;
      r_pkt_start  <= w_pkt_start;
      r_commit_ptr <= w_commit;
      r_pkt_cnt    <= r_pkt_cnt + w_n_pkt;
      r_ovf_cnt    <= r_ovf_cnt + w_n_ovf;
      r_err_cnt    <= r_err_cnt + w_n_err;
    end
  end

  // Packer slot contents; only slots below r_fill are ever consumed.
  always_ff @(posedge clk) begin
    r_slot_data <= w_slot_data;
    r_slot_keep <= w_slot_keep;
  end

  // FIFO storage; a later beat in the same cycle wins on an address clash.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SEG; i++) begin
      if (w_we[i]) r_mem[w_waddr[i]] <= w_wentry[i];
    end
  end

  // ---- stage 3: registered AXIS output ----
  logic          r_tvalid, r_tlast, r_tuser;
  logic [DW-1:0] r_tdata;
  logic [KW-1:0] r_tkeep;
  logic          w_load;

  assign w_load = (r_rd_ptr != r_commit_ptr) && (!r_tvalid || m_axis_tready);

  // Load the next committed beat when the output is empty or being taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tuser   <= 1'b0;
      r_tdata   <= '0;
      r_tkeep   <= '0;
      r_rd_ptr  <= '0;
      r_rel_ptr <= '0;
    end else begin
      if (r_tvalid && m_axis_tready) r_rel_ptr <= r_rel_ptr + PW'(1);
      if (w_load) begin
        r_tvalid <= 1'b1;
        {r_tdata, r_tkeep, r_tlast, r_tuser} <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tvalid = r_tvalid;
  assign pkt_cnt       = r_pkt_cnt;
  assign drop_ovf_cnt  = r_ovf_cnt;
  assign drop_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_lbus2axis_pkt_fifo.sv
// Directed bench for lbus2axis_pkt_fifo: two 4-segment, 16-deep instances,
// one dropping errored packets and one forwarding them with tuser.
`timescale 1ns/1ps
module tb_lbus2axis_pkt_fifo;
  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
    logic         u;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] data;
  logic [3:0]   ena, sop, eop, err;
  logic [15:0]  mty;
  logic         tready;
  int           tr_mode;  // 0 = hold low, 1 = hold high, 2 = random

  logic [511:0] a_tdata, f_tdata;
  logic [63:0]  a_tkeep, f_tkeep;
  logic         a_tlast, a_tuser, a_tvalid, f_tlast, f_tuser, f_tvalid;
  logic [31:0]  a_pkt_cnt, a_ovf_cnt, a_err_cnt, f_pkt_cnt, f_ovf_cnt, f_err_cnt;

  int    total = 0;
  int    bad = 0;
  beat_t q_a[$];
  beat_t q_f[$];
  beat_t cur_a, cur_f, prev_a;
  logic  hold_a = 1'b0;

  always #5 clk = ~clk;

  lbus2axis_pkt_fifo #(.NUM_SEG(4), .DEPTH(16), .DROP_ERR(1), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rx_lbus_data(data), .rx_lbus_ena(ena), .rx_lbus_sop(sop), .rx_lbus_eop(eop),
    .rx_lbus_mty(mty), .rx_lbus_err(err),
    .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tlast(a_tlast),
    .m_axis_tuser(a_tuser), .m_axis_tvalid(a_tvalid), .m_axis_tready(tready),
    .pkt_cnt(a_pkt_cnt), .drop_ovf_cnt(a_ovf_cnt), .drop_err_cnt(a_err_cnt));

  lbus2axis_pkt_fifo #(.NUM_SEG(4), .DEPTH(16), .DROP_ERR(0), .CNT_W(32)) u_fwd (
    .clk(clk), .rst_n(rst_n),
    .rx_lbus_data(data), .rx_lbus_ena(ena), .rx_lbus_sop(sop), .rx_lbus_eop(eop),
    .rx_lbus_mty(mty), .rx_lbus_err(err),
    .m_axis_tdata(f_tdata), .m_axis_tkeep(f_tkeep), .m_axis_tlast(f_tlast),
    .m_axis_tuser(f_tuser), .m_axis_tvalid(f_tvalid), .m_axis_tready(tready),
    .pkt_cnt(f_pkt_cnt), .drop_ovf_cnt(f_ovf_cnt), .drop_err_cnt(f_err_cnt));

  assign cur_a = {a_tdata, a_tkeep, a_tlast, a_tuser};
  assign cur_f = {f_tdata, f_tkeep, f_tlast, f_tuser};

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // tready driver, acting 2 ns after each rising edge
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (tr_mode == 0) tready = 1'b0;
      else if (tr_mode == 1) tready = 1'b1;
      else tready = 1'($urandom_range(0, 1));
    end
  end

  // Capture handshaken beats and check hold-under-backpressure on u_dut.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_a <= 1'b0;
    end else begin
      if (hold_a) chk("hold", {511'b0, (a_tvalid === 1'b1) && (cur_a === prev_a)}, 512'd1);
      if (a_tvalid && tready) q_a.push_back(cur_a);
      if (f_tvalid && tready) q_f.push_back(cur_f);
      hold_a <= a_tvalid && !tready;
      prev_a <= cur_a;
    end
  end

  function automatic logic [127:0] sw(input int p, input int n);
    logic [7:0] pb, nb;
    pb = p[7:0];
    nb = n[7:0];
    return {4{pb, nb, 16'hC0DE}};
  endfunction

  function automatic beat_t b64(input int p, input logic u);
    beat_t b;
    b.d = {sw(p, 0), sw(p, 1), sw(p, 2), sw(p, 3)};
    b.k = 64'hFFFF_FFFF_FFFF_FFFF;
    b.l = 1'b1;
    b.u = u;
    return b;
  endfunction

  function automatic logic [511:0] smask(input logic [63:0] k);
    logic [511:0] m;
    m = '0;
    for (int s = 0; s < 4; s++) if (k[(3-s)*16 +: 16] != 16'h0) m[(3-s)*128 +: 128] = '1;
    return m;
  endfunction

  task automatic expb(input int which, input string tag, input beat_t e);
    beat_t g;
    int    sz;
    sz = (which == 0) ? q_a.size() : q_f.size();
    if (sz == 0) begin
      chk({tag, "_present"}, 512'd0, 512'd1);
      return;
    end
    if (which == 0) g = q_a.pop_front();
    else g = q_f.pop_front();
    chk({tag, "_d"}, g.d & smask(e.k), e.d & smask(e.k));
    chk({tag, "_k"}, g.k, e.k);
    chk({tag, "_lu"}, {g.l, g.u}, {e.l, e.u});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] e, input logic [3:0] s, input logic [3:0] o,
                       input logic [15:0] m, input logic [3:0] r,
                       input logic [127:0] d0, input logic [127:0] d1,
                       input logic [127:0] d2, input logic [127:0] d3);
    ena = e; sop = s; eop = o; mty = m; err = r; data = {d0, d1, d2, d3};
    tick(1);
    ena = '0; sop = '0; eop = '0; mty = '0; err = '0;
  endtask

  task automatic pkt64(input int p, input logic e);
    drive(4'hF, 4'h1, 4'h8, 16'h0, {e, 3'b000}, sw(p, 0), sw(p, 1), sw(p, 2), sw(p, 3));
  endtask

  initial begin
    beat_t e;
    ena = '0; sop = '0; eop = '0; mty = '0; err = '0; data = '0;
    tr_mode = 1;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_tvalid", a_tvalid, 0);
    chk("rst_tdata", a_tdata, 0);
    chk("rst_tkeep", a_tkeep, 0);
    chk("rst_cnts", {a_pkt_cnt, a_ovf_cnt, a_err_cnt}, 0);

    // 64 B packet in one cycle: first beat valid three cycles later
    pkt64(1, 1'b0);
    chk("lat_c1", a_tvalid, 0);
    tick(1);
    chk("lat_c2", a_tvalid, 0);
    tick(1);
    chk("lat_c3", a_tvalid, 1);
    chk("lat_d", a_tdata, {sw(1, 0), sw(1, 1), sw(1, 2), sw(1, 3)});
    chk("lat_k", a_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("lat_lu", {a_tlast, a_tuser}, 2'b10);
    chk("lat_cnt", a_pkt_cnt, 1);
    tick(2);
    chk("lat_after", a_tvalid, 0);
    expb(0, "lat_q", b64(1, 1'b0));

    // 65 B packet starting on segment 1
    drive(4'b1110, 4'b0010, 4'b0000, 16'h0000, 4'h0, '0, sw(2, 1), sw(2, 2), sw(2, 3));
    drive(4'b0011, 4'b0000, 4'b0010, 16'h00F0, 4'h0, sw(2, 4), sw(2, 5), '0, '0);
    tick(6);
    e = '{d: {sw(2, 1), sw(2, 2), sw(2, 3), sw(2, 4)}, k: 64'hFFFF_FFFF_FFFF_FFFF, l: 1'b0, u: 1'b0};
    expb(0, "b65_0", e);
    e = '{d: {sw(2, 5), 384'h0}, k: 64'h8000_0000_0000_0000, l: 1'b1, u: 1'b0};
    expb(0, "b65_1", e);

    // eop on seg0 and sop on seg1 in the same cycle, then a 2-beat packet
    drive(4'b1110, 4'b0010, 4'b0000, 16'h0000, 4'h0, '0, sw(3, 0), sw(3, 1), sw(3, 2));
    drive(4'b1111, 4'b0010, 4'b0001, 16'h0000, 4'h0, sw(3, 3), sw(4, 0), sw(4, 1), sw(4, 2));
    drive(4'b0011, 4'b0000, 4'b0010, 16'h0040, 4'h0, sw(4, 3), sw(4, 4), '0, '0);
    tick(6);
    expb(0, "b2b_p3", b64(3, 1'b0));
    e = '{d: {sw(4, 0), sw(4, 1), sw(4, 2), sw(4, 3)}, k: 64'hFFFF_FFFF_FFFF_FFFF, l: 1'b0, u: 1'b0};
    expb(0, "b2b_p4a", e);
    e = '{d: {sw(4, 4), 384'h0}, k: 64'hFFF0_0000_0000_0000, l: 1'b1, u: 1'b0};
    expb(0, "b2b_p4b", e);
    chk("b2b_cnt", a_pkt_cnt, 4);

    // err on eop: dropped by u_dut, forwarded with tuser by u_fwd
    q_f.delete();
    pkt64(5, 1'b1);
    tick(6);
    chk("err_none", q_a.size(), 0);
    chk("err_cnt", a_err_cnt, 1);
    chk("err_pkt", a_pkt_cnt, 4);
    chk("fwd_pkt", f_pkt_cnt, 5);
    chk("fwd_err", f_err_cnt, 0);
    expb(1, "fwd_beat", b64(5, 1'b1));

    // sop inside an open packet: old one dropped, new one delivered
    drive(4'b0011, 4'b0001, 4'b0000, 16'h0000, 4'h0, sw(6, 0), sw(6, 1), '0, '0);
    pkt64(7, 1'b0);
    tick(6);
    chk("viol_err", a_err_cnt, 2);
    chk("viol_pkt", a_pkt_cnt, 5);
    expb(0, "viol_p7", b64(7, 1'b0));
    chk("viol_q", q_a.size(), 0);

    // overflow: 17 packets into 16 entries with the sink stalled
    tr_mode = 0;
    q_f.delete();
    for (int p = 0; p < 17; p++) pkt64(10 + p, 1'b0);
    tick(8);
    chk("ovf_cnt", a_ovf_cnt, 1);
    chk("ovf_pkt", a_pkt_cnt, 21);
    chk("ovf_held", a_tvalid, 1);
    chk("ovf_head", a_tdata, b64(10, 1'b0).d);
    tr_mode = 1;
    tick(25);
    chk("ovf_beats", q_a.size(), 16);
    for (int p = 0; p < 16; p++) expb(0, $sformatf("ovf_p%0d", p), b64(10 + p, 1'b0));
    q_f.delete();

    // async reset mid-packet with a beat stalled on the output
    tr_mode = 0;
    pkt64(40, 1'b0);
    tick(4);
    chk("pre_rst_vld", a_tvalid, 1);
    drive(4'hF, 4'h1, 4'h0, 16'h0, 4'h0, sw(41, 0), sw(41, 1), sw(41, 2), sw(41, 3));
    rst_n = 1'b0;
    #1;
    chk("arst_vld", a_tvalid, 0);
    chk("arst_data", {a_tdata, a_tkeep, a_tlast, a_tuser}, 0);
    chk("arst_cnts", {a_pkt_cnt, a_ovf_cnt, a_err_cnt}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    q_a.delete();
    q_f.delete();

    // orphan continuation, then traffic under random backpressure
    tr_mode = 2;
    drive(4'b0001, 4'b0000, 4'b0001, 16'h0000, 4'h0, sw(41, 4), '0, '0, '0);
    pkt64(50, 1'b0);
    drive(4'b1110, 4'b0010, 4'b0000, 16'h0000, 4'h0, '0, sw(51, 1), sw(51, 2), sw(51, 3));
    drive(4'b0011, 4'b0000, 4'b0010, 16'h00F0, 4'h0, sw(51, 4), sw(51, 5), '0, '0);
    pkt64(52, 1'b0);
    pkt64(53, 1'b0);
    pkt64(54, 1'b0);
    tick(40);
    tr_mode = 1;
    tick(10);
    chk("rnd_pkt", a_pkt_cnt, 5);
    chk("rnd_err", a_err_cnt, 0);
    chk("rnd_beats", q_a.size(), 6);
    expb(0, "rnd_p50", b64(50, 1'b0));
    e = '{d: {sw(51, 1), sw(51, 2), sw(51, 3), sw(51, 4)}, k: 64'hFFFF_FFFF_FFFF_FFFF, l: 1'b0, u: 1'b0};
    expb(0, "rnd_p51a", e);
    e = '{d: {sw(51, 5), 384'h0}, k: 64'h8000_0000_0000_0000, l: 1'b1, u: 1'b0};
    expb(0, "rnd_p51b", e);
    expb(0, "rnd_p52", b64(52, 1'b0));
    expb(0, "rnd_p53", b64(53, 1'b0));
    expb(0, "rnd_p54", b64(54, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
